// File: rtl/csa_resolve_seq.sv
// rtl/csa_resolve_seq.sv - multi-cycle carry-save resolver with leading-zero count
// Adds one sum/carry pair chunk by chunk, LSB first, then registers the LZC of the result.
module csa_resolve_seq #(
  parameter int SIG_WIDTH = 23,
  parameter int CHUNK     = 16,
  parameter int LZW       = 6,
  localparam int W        = 2 * (SIG_WIDTH + 1) + 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_sum,
  input  logic [W-1:0]   in_carry,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   res,
  output logic [LZW-1:0] lzc,
  output logic           zero,
  output logic           ovf
);

  localparam int N         = (W + CHUNK - 1) / CHUNK;
  localparam int NW        = N * CHUNK;
  localparam int LAST_BITS = W - (N - 1) * CHUNK;
  localparam int IW        = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_LZC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cin_q, cin_d;
  logic [W-1:0]    res_q, res_d;
  logic [LZW-1:0]  lzc_q, lzc_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;

  logic            accept;
  logic            last_chunk;
  int              base;
  logic [CHUNK:0]  chunk_sum;
  logic [NW-1:0]   res_ext;
  logic [LZW-1:0]  lzc_calc;

  assign accept     = in_valid && (state_q == S_IDLE);
  assign last_chunk = (idx_q == IW'(N - 1));
  assign base       = int'(idx_q) * CHUNK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)   state_d = S_ADD;
      S_ADD:   if (last_chunk) state_d = S_LZC;
      S_LZC:                   state_d = S_DONE;
      S_DONE:  if (out_ready)  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Operands are zero-extended so the partial top chunk leaves its carry
  // at bit LAST_BITS of chunk_sum, which is exactly the W-bit carry out.
  always_comb begin
    chunk_sum = {1'b0, op_a_q[base +: CHUNK]} + {1'b0, op_b_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, cin_q};
    res_ext          = '0;
    res_ext[W-1:0]   = res_q;
    res_ext[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    lzc_calc = LZW'(W);
    for (int i = 0; i < W; i++) begin
      if (res_q[i]) lzc_calc = LZW'(W - 1 - i);
    end
  end

  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    idx_d  = idx_q;
    cin_d  = cin_q;
    res_d  = res_q;
    lzc_d  = lzc_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    case (state_q)
      S_IDLE: if (accept) begin
        op_a_d         = '0;
        op_b_d         = '0;
        op_a_d[W-1:0]  = in_sum;
        op_b_d[W-1:0]  = in_carry;
        idx_d          = '0;
        cin_d          = 1'b0;
      end
      S_ADD: begin
        res_d = res_ext[W-1:0];
        idx_d = idx_q + IW'(1);
        if (last_chunk) ovf_d = chunk_sum[LAST_BITS];
        else            cin_d = chunk_sum[CHUNK];
      end
      S_LZC: begin
        lzc_d  = lzc_calc;
        zero_d = (res_q == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q <= '0;
      op_b_q <= '0;
      idx_q  <= '0;
      cin_q  <= 1'b0;
      res_q  <= '0;
      lzc_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      idx_q  <= idx_d;
      cin_q  <= cin_d;
      res_q  <= res_d;
      lzc_q  <= lzc_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign res  = res_q;
  assign lzc  = lzc_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_csa_resolve_seq.sv
// tb/tb_csa_resolve_seq.sv - directed self-checking bench for csa_resolve_seq
module tb_csa_resolve_seq;

  localparam int W   = 53;
  localparam int LZW = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_sum;
  logic [W-1:0]   in_carry;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   res;
  logic [LZW-1:0] lzc;
  logic           zero;
  logic           ovf;

  int checks   = 0;
  int failures = 0;

  csa_resolve_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .lzc       (lzc),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a pair and wait for the accept edge; returns #1 after that edge.
  task automatic start_op(input logic [W-1:0] s, input logic [W-1:0] c);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sum   = '1;
    in_carry = '1;
  endtask

  task automatic wait_result(input string tag, input logic [W-1:0] e_res,
                             input int e_lzc, input logic e_zero, input logic e_ovf);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd5);
    check({tag, "_res"}, 64'(res), 64'(e_res));
    check({tag, "_lzc"}, 64'(lzc), 64'(e_lzc));
    check({tag, "_zero"}, {63'd0, zero}, {63'd0, e_zero});
    check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, e_ovf});
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_hs_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_hs_ready"}, {63'd0, in_ready}, 64'd1);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] s, input logic [W-1:0] c,
                        input logic [W-1:0] e_res, input int e_lzc,
                        input logic e_zero, input logic e_ovf);
    start_op(s, c);
    wait_result(tag, e_res, e_lzc, e_zero, e_ovf);
    handshake(tag);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_lzc", 64'(lzc), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("one_plus_one", 53'd1, 53'd1, 53'd2, 51, 1'b0, 1'b0);
    run_op("chunk_carry", 53'hFFFF, 53'd1, 53'h1_0000, 36, 1'b0, 1'b0);
    run_op("ripple_3", 53'hFFFF_FFFF_FFFF, 53'd1, 53'h1_0000_0000_0000, 4, 1'b0, 1'b0);
    run_op("wrap_zero", 53'h1F_FFFF_FFFF_FFFF, 53'd1, 53'd0, 53, 1'b1, 1'b1);
    run_op("top_bit", 53'h10_0000_0000_0000, 53'd0, 53'h10_0000_0000_0000, 0, 1'b0, 1'b0);
    run_op("max_max", 53'h1F_FFFF_FFFF_FFFF, 53'h1F_FFFF_FFFF_FFFF,
           53'h1F_FFFF_FFFF_FFFE, 0, 1'b0, 1'b1);
    run_op("zero_zero", 53'd0, 53'd0, 53'd0, 53, 1'b1, 1'b0);
    run_op("no_carry", 53'h1234, 53'h4321, 53'h5555, 38, 1'b0, 1'b0);

    // Backpressure: result held in DONE, new in_valid ignored.
    start_op(53'h0_00AB_0000_0000, 53'h0_0001_0000_0000);
    wait_result("bp", 53'h0_00AC_0000_0000, 13, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sum   = 53'd5;
      in_carry = 53'd6;
      @(posedge clk);
      #1;
      check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      check("bp_hold_res", 64'(res), 64'h00AC_0000_0000);
      check("bp_hold_lzc", 64'(lzc), 64'd13);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    handshake("bp");
    run_op("after_bp", 53'd100, 53'd28, 53'd128, 45, 1'b0, 1'b0);

    // Asynchronous reset two cycles into ADD.
    start_op(53'h1F_0000_0000_0000, 53'h0_FFFF_FFFF_FFFF);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_res", 64'(res), 64'd0);
    check("arst_lzc", 64'(lzc), 64'd0);
    check("arst_zero", {63'd0, zero}, 64'd0);
    check("arst_ovf", {63'd0, ovf}, 64'd0);
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 53'd3, 53'd4, 53'd7, 50, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
